sparc_mem_ctrl: RTL

//  Memory-access sequencer between the SPARC datapath (MAR/MDR, MOV, RW, type) and a word-wide synchronous RAM.

---
 rtl/sparc_mem_ctrl_pkg.sv | 34 +++
 rtl/sparc_lane_steer.sv | 41 ++++
 rtl/sparc_mem_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sparc_mem_ctrl_pkg.sv
// Shared definitions for the SPARC memory-access sequencer:
// access-size encodings, FSM states, wait-state bounds and the alignment rule.
package sparc_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    TYPE_BYTE  = 2'b00,
    TYPE_HALF  = 2'b01,
    TYPE_WORD  = 2'b10,
    TYPE_DWORD = 2'b11
  } mem_type_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;
  localparam int WCNT_W   = 4;

  // Natural alignment: the low address bits below the access size must be zero.
  function automatic logic is_aligned(input mem_type_e t, input logic [2:0] a);
    case (t)
      TYPE_BYTE: return 1'b1;
      TYPE_HALF: return (a[0] == 1'b0);
      TYPE_WORD: return (a[1:0] == 2'b00);
      default:   return (a == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/sparc_lane_steer.sv
// Big-endian byte-lane steering between the 64-bit datapath and a 32-bit RAM word:
// byte enables and replicated write data for stores, lane select plus extension for loads.
module sparc_lane_steer
  import sparc_mem_ctrl_pkg::*;
(
  input  mem_type_e   type_i,
  input  logic [1:0]  off_i,
  input  logic        sext_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Byte offset 0 is the most significant lane; word and dword beats pass straight through.
  always_comb begin
    byte_v  = 8'(rdata_i >> {~off_i, 3'b000});
    half_v  = 16'(rdata_i >> {~off_i[1], 4'b0000});
    be_o    = 4'b1111;
    wdata_o = sdata_i;
    load_o  = rdata_i;
    case (type_i)
      TYPE_BYTE: begin
        be_o    = 4'b1000 >> off_i;
        wdata_o = {4{sdata_i[7:0]}};
        load_o  = sext_i ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      end
      TYPE_HALF: begin
        be_o    = off_i[1] ? 4'b0011 : 4'b1100;
        wdata_o = {2{sdata_i[15:0]}};
        load_o  = sext_i ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sparc_mem_ctrl.sv
// Memory-access sequencer: accepts one load/store per MOV request, runs one or two
// word beats with a fixed number of RAM wait states, and returns MOC to the control unit.
module sparc_mem_ctrl
  import sparc_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        Type,
  input  logic              SignExt,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [63:0]       DataIn,
  output logic [63:0]       DataOut,
  output logic              MOC,
  output logic              AlignErr,
  output logic              Busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Out-of-range wait counts are clamped into what the counter can represent.
  localparam int WaitEff = (WAIT_CYCLES < WAIT_MIN) ? WAIT_MIN :
                           (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
  localparam logic [WCNT_W-1:0] WaitInit = WCNT_W'(WaitEff);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  mem_type_e         type_q, type_d;
  logic              rw_q, rw_d;
  logic              sext_q, sext_d;
  logic [63:0]       data_q, data_d;
  logic              misal_q, misal_d;
  logic              beat_q, beat_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [31:0]       word1_q, word1_d;
  logic [63:0]       dout_q, dout_d;

  logic [31:0] beat_data;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] load_s;

  assign beat_data = (type_q == TYPE_DWORD && !beat_q) ? data_q[63:32] : data_q[31:0];
  assign DataOut   = dout_q;

  sparc_lane_steer u_steer (
    .type_i  (type_q),
    .off_i   (addr_q[1:0]),
    .sext_i  (sext_q),
    .sdata_i (beat_data),
    .rdata_i (mem_rdata),
    .be_o    (be_s),
    .wdata_o (wdata_s),
    .load_o  (load_s)
  );

  // State and capture registers; Clr low abandons any access in flight.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      type_q  <= TYPE_BYTE;
      rw_q    <= 1'b0;
      sext_q  <= 1'b0;
      data_q  <= '0;
      misal_q <= 1'b0;
      beat_q  <= 1'b0;
      wcnt_q  <= '0;
      word1_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      rw_q    <= rw_d;
      sext_q  <= sext_d;
      data_q  <= data_d;
      misal_q <= misal_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
      word1_q <= word1_d;
      dout_q  <= dout_d;
    end
  end

  // Sequencing and RAM strobes; RAM-side outputs are forced to zero outside ACCESS.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    type_d    = type_q;
    rw_d      = rw_q;
    sext_d    = sext_q;
    data_d    = data_q;
    misal_d   = misal_q;
    beat_d    = beat_q;
    wcnt_d    = wcnt_q;
    word1_d   = word1_q;
    dout_d    = dout_q;
    MOC       = 1'b0;
    AlignErr  = 1'b0;
    Busy      = (state_q != ST_IDLE);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (MOV) begin
          addr_d  = Addr;
          type_d  = mem_type_e'(Type);
          rw_d    = RW;
          sext_d  = SignExt;
          data_d  = DataIn;
          beat_d  = 1'b0;
          misal_d = ~is_aligned(mem_type_e'(Type), Addr[2:0]);
          state_d = misal_d ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = ~rw_q;
        mem_be    = be_s;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00} + (beat_q ? ADDR_W'(4) : ADDR_W'(0));
        mem_wdata = rw_q ? 32'h0 : wdata_s;
        wcnt_d    = WaitInit;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q == WCNT_W'(1)) begin
          if (rw_q) begin
            if (type_q == TYPE_DWORD) begin
              if (!beat_q) word1_d = mem_rdata;
              else         dout_d  = {word1_q, mem_rdata};
            end else begin
              dout_d = {32'h0, load_s};
            end
          end
          if (type_q == TYPE_DWORD && !beat_q) begin
            beat_d  = 1'b1;
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        MOC      = 1'b1;
        AlignErr = misal_q;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        if (!MOV) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
